// File: rtl/act_mem_loader.sv
// act_mem_loader: streams DATA_W words into one half of the activation memory.
// Macro ACT_LOADER_CHECKSUM_EN adds a running sum of accepted words on checksum_o.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   start_i, abort_i         transfer control
//   buffer_sel_i             0 = lower half, 1 = upper half
//   base_off_i, n_words_i    transfer start offset and length
//   in_valid_i/in_data_i     input stream, in_ready_o back-pressure
//   mem_wr_en_o/addr/wdata/be  registered SRAM write port
//   busy_o, done_o, err_o    status: busy, completion pulse, sticky wrap error
//   checksum_o               running checksum (zero unless the macro is defined)
module act_mem_loader #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 14,
    parameter int BYTES_PER_ROW = 4,
    parameter int CNT_W         = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     buffer_sel_i,
    input  logic [ADDR_W-2:0]        base_off_i,
    input  logic [CNT_W-1:0]         n_words_i,
    input  logic                     in_valid_i,
    input  logic [DATA_W-1:0]        in_data_i,
    output logic                     in_ready_o,
    output logic                     mem_wr_en_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    output logic [BYTES_PER_ROW-1:0] mem_be_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [DATA_W-1:0]        checksum_o
);

    localparam int OFF_W = ADDR_W - 1;

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t                   state_q, state_d;
    logic                     sel_q, sel_d;
    logic [OFF_W-1:0]         off_q, off_d;
    logic [CNT_W-1:0]         rem_q, rem_d;
    logic                     wrap_q, wrap_d;
    logic                     wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;
    logic [BYTES_PER_ROW-1:0] be_q, be_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
`ifdef ACT_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]        csum_q, csum_d;
`endif

    logic             hs;
    logic [OFF_W:0]   off_inc;

    assign in_ready_o = (state_q == LOAD);
    assign busy_o     = (state_q == LOAD);
    // A word presented together with abort is flushed, not written.
    assign hs         = in_valid_i & in_ready_o & ~abort_i;
    assign off_inc    = {1'b0, off_q} + (OFF_W + 1)'(BYTES_PER_ROW);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        off_d   = off_q;
        rem_d   = rem_q;
        wrap_d  = wrap_q;
        wr_en_d = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        be_d    = '0;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef ACT_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    sel_d  = buffer_sel_i;
                    off_d  = base_off_i & ~OFF_W'(BYTES_PER_ROW - 1);
                    rem_d  = n_words_i;
                    wrap_d = 1'b0;
                    err_d  = 1'b0;
`ifdef ACT_LOADER_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (n_words_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (hs) begin
                    wr_en_d = 1'b1;
                    addr_d  = {sel_q, off_q};
                    wdata_d = in_data_i;
                    be_d    = '1;
                    off_d   = off_inc[OFF_W-1:0];
                    rem_d   = rem_q - CNT_W'(1);
                    // The offset has wrapped; the error is raised together
                    // with the first write landing at the buffer start.
                    if (off_inc[OFF_W]) wrap_d = 1'b1;
                    if (wrap_q) err_d = 1'b1;
`ifdef ACT_LOADER_CHECKSUM_EN
                    csum_d  = csum_q + in_data_i;
`endif
                    if (rem_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            off_q   <= '0;
            rem_q   <= '0;
            wrap_q  <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            rem_q   <= rem_d;
            wrap_q  <= wrap_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef ACT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum_o = csum_q;
`else
    assign checksum_o = '0;
`endif

    assign mem_wr_en_o = wr_en_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_act_mem_loader.sv
// tb_act_mem_loader: directed self-checking bench for act_mem_loader.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_act_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, sel, in_valid;
    logic [12:0] base_off;
    logic [11:0] n_words;
    logic [31:0] in_data;
    logic        in_ready, wr_en, busy, done, err;
    logic [13:0] addr;
    logic [31:0] wdata, csum;
    logic [3:0]  be;

    int checks   = 0;
    int failures = 0;

    act_mem_loader dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .buffer_sel_i(sel),
        .base_off_i  (base_off),
        .n_words_i   (n_words),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .mem_wr_en_o (wr_en),
        .mem_addr_o  (addr),
        .mem_wdata_o (wdata),
        .mem_be_o    (be),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .checksum_o  (csum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cs(input logic [31:0] v);
`ifdef ACT_LOADER_CHECKSUM_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_xfer(input logic s, input logic [12:0] b,
                              input logic [11:0] n);
        start = 1'b1; sel = s; base_off = b; n_words = n;
        tick;
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] d);
        in_valid = 1'b1; in_data = d;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic [13:0] a,
                          input logic [31:0] d, input logic dn);
        check({tag, "_wr"}, 32'(wr_en), 32'd1);
        check({tag, "_addr"}, 32'(addr), 32'(a));
        check({tag, "_data"}, wdata, d);
        check({tag, "_be"}, 32'(be), 32'hF);
        check({tag, "_done"}, 32'(done), 32'(dn));
    endtask

    logic [31:0] words [4];
    logic        vpat  [5];
    logic [13:0] apat  [5];

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0;
        in_valid = 1'b0; base_off = '0; n_words = '0; in_data = '0;
        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr", 32'(wr_en), 32'd0);
        check("rst_outs", {addr, 4'h0, be, 9'h0, done, err}, 32'h0);
        check("rst_csum", csum, 32'h0);
        rst_n = 1'b1;
        tick;

        // Basic load
        begin_xfer(1'b0, 13'h0010, 12'd4);
        check("b_busy", 32'(busy), 32'd1);
        check("b_ready", 32'(in_ready), 32'd1);
        check("b_nowr", 32'(wr_en), 32'd0);
        for (int i = 0; i < 4; i++) begin
            feed(words[i]);
            chk_wr($sformatf("b%0d", i), 14'h0010 + 14'(4 * i), words[i],
                   i == 3);
        end
        check("b_busy_end", 32'(busy), 32'd0);
        check("b_ready_end", 32'(in_ready), 32'd0);
        check("b_err", 32'(err), 32'd0);
        check("b_csum", csum, cs(32'hAAAAAAAA));
        tick;
        check("b_idle_wr", 32'(wr_en), 32'd0);
        check("b_idle_be", 32'(be), 32'd0);
        check("b_idle_done", 32'(done), 32'd0);

        // Upper buffer with offset wrap
        begin_xfer(1'b1, 13'h1FF8, 12'd3);
        feed(32'hA0);
        chk_wr("w0", 14'h3FF8, 32'hA0, 1'b0);
        check("w0_err", 32'(err), 32'd0);
        feed(32'hA1);
        chk_wr("w1", 14'h3FFC, 32'hA1, 1'b0);
        check("w1_err", 32'(err), 32'd0);
        feed(32'hA2);
        chk_wr("w2", 14'h2000, 32'hA2, 1'b1);
        check("w2_err", 32'(err), 32'd1);
        tick;
        check("w_err_hold", 32'(err), 32'd1);

        // Backpressure; unaligned base is rounded down, start clears err
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        apat = '{14'h0100, 14'h0, 14'h0, 14'h0104, 14'h0108};
        begin_xfer(1'b0, 13'h0102, 12'd3);
        check("bp_err_clr", 32'(err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = vpat[i]; in_data = 32'hB0 + 32'(i);
            tick;
            in_valid = 1'b0;
            if (vpat[i]) chk_wr($sformatf("bp%0d", i), apat[i],
                                32'hB0 + 32'(i), i == 4);
            else check($sformatf("bp%0d_nowr", i), 32'(wr_en), 32'd0);
        end

        // Zero-length start
        begin_xfer(1'b0, 13'h0, 12'd0);
        check("z_done", 32'(done), 32'd1);
        check("z_busy", 32'(busy), 32'd0);
        tick;
        check("z_done_off", 32'(done), 32'd0);
        check("z_busy2", 32'(busy), 32'd0);

        // Start during LOAD is ignored
        begin_xfer(1'b0, 13'h0040, 12'd2);
        start = 1'b1; sel = 1'b1; base_off = 13'h0080; n_words = 12'd5;
        feed(32'hC0);
        start = 1'b0;
        chk_wr("ig0", 14'h0040, 32'hC0, 1'b0);
        feed(32'hC1);
        chk_wr("ig1", 14'h0044, 32'hC1, 1'b1);

        // Abort with a concurrent valid word
        begin_xfer(1'b0, 13'h0, 12'd8);
        for (int i = 0; i < 3; i++) begin
            feed(32'hD0 + 32'(i));
            chk_wr($sformatf("ab%0d", i), 14'(4 * i), 32'hD0 + 32'(i), 1'b0);
        end
        abort = 1'b1;
        feed(32'hD3);
        abort = 1'b0;
        check("ab_nowr", 32'(wr_en), 32'd0);
        check("ab_nodone", 32'(done), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        begin_xfer(1'b0, 13'h0020, 12'd1);
        feed(32'h5);
        chk_wr("ab_restart", 14'h0020, 32'h5, 1'b1);
        check("ab_csum", csum, cs(32'h5));

        // Async reset in the middle of a transfer
        begin_xfer(1'b1, 13'h0, 12'd5);
        feed(32'hE0);
        feed(32'hE1);
        chk_wr("r1", 14'h2004, 32'hE1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("r_wr", 32'(wr_en), 32'd0);
        check("r_busy", 32'(busy), 32'd0);
        check("r_ready", 32'(in_ready), 32'd0);
        check("r_addr", 32'(addr), 32'd0);
        check("r_csum", csum, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 32'hE2;
        tick;
        in_valid = 1'b0;
        check("r_post_ready", 32'(in_ready), 32'd0);
        check("r_post_busy", 32'(busy), 32'd0);
        check("r_post_wr", 32'(wr_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
